// File: rtl/priority_index_sequencer.sv
// Captures an N-bit request vector, then streams the indices of its set bits
// in priority order (at most MAX_OUT beats) over a valid/ready output.
module priority_index_sequencer #(
  parameter int N         = 12,
  parameter int MAX_OUT   = 2,
  parameter int LSB_FIRST = 0,
  localparam int IW = $clog2(N),
  localparam int RW = ($clog2(MAX_OUT) > 1) ? $clog2(MAX_OUT) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [RW-1:0] out_rank,
  output logic          out_last,
  output logic          out_none,
  output logic [CW-1:0] count
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [RW-1:0] rank_q, rank_d;
  logic [CW-1:0] count_q, count_d;
  logic          zero_q, zero_d;

  logic [IW-1:0] sel_idx;
  logic [N-1:0]  sel_mask;
  logic [CW-1:0] req_pop;
  logic          one_left;
  logic          last_beat;

  // Later iterations override earlier ones, so the loop direction sets priority.
  always_comb begin
    sel_idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = IW'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    req_pop = '0;
    for (int i = 0; i < N; i++) begin
      req_pop = req_pop + CW'(req[i]);
    end
  end

  assign sel_mask  = {{(N-1){1'b0}}, 1'b1} << sel_idx;
  assign one_left  = ~|(pending_q & (pending_q - {{(N-1){1'b0}}, 1'b1}));
  assign last_beat = zero_q || one_left || (rank_q == RW'(MAX_OUT - 1));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rank_d    = rank_q;
    count_d   = count_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pending_d = req;
          rank_d    = '0;
          count_d   = req_pop;
          zero_d    = (req == '0);
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_beat) begin
            pending_d = '0;
            rank_d    = '0;
            state_d   = S_IDLE;
          end else begin
            pending_d = pending_q & ~sel_mask;
            rank_d    = rank_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rank_q    <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rank_q    <= rank_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  // Outputs decode registered state only; nothing from the inputs reaches them.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_EMIT);
  assign out_idx   = zero_q ? '0 : sel_idx;
  assign out_rank  = rank_q;
  assign out_last  = (state_q == S_EMIT) && last_beat;
  assign out_none  = (state_q == S_EMIT) && zero_q;
  assign count     = count_q;

endmodule
